// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = producer of operands and consumer of results.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, x, y, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, one carry slice per stage.
// Operands skew in, result slices deskew out; elastic valid/ready flow.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    typedef logic [WIDTH-1:0] word_t;

    word_t [STAGES-1:0] a_q, b_q, s_q;
    word_t [STAGES-1:0] a_d, b_d, s_d;
    logic  [STAGES-1:0] v_q, c_q, v_d, c_d;
    logic  [STAGES-1:0] rdy;
    logic               ovf_q, zero_q, ovf_d, zero_d;

    word_t [STAGES:0]   a_in, b_in, s_in;
    logic  [STAGES:0]   c_in, v_in;
    word_t              beff;
    logic               c0;
    logic               acc;
    logic               cm;
    logic  [SW:0]       slc;
    logic               unused_tail;

    assign beff = bus.sub ? ~bus.y : bus.y;
    assign c0   = bus.sub | bus.cin;

    // Element k is what stage k loads from; element 0 is the input port.
    assign a_in = {a_q, bus.x};
    assign b_in = {b_q, beff};
    assign s_in = {s_q, word_t'('0)};
    assign c_in = {c_q, c0};
    assign v_in = {v_q, bus.in_valid};

    assign unused_tail = ^{a_in[STAGES], b_in[STAGES], s_in[STAGES],
                           c_in[STAGES], v_in[STAGES]};

    // A stage can load if it or any stage after it is empty, or out drains.
    always_comb begin
        rdy = '0;
        acc = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            rdy[k] = acc;
        end
    end

    always_comb begin
        a_d    = '0;
        b_d    = '0;
        s_d    = '0;
        c_d    = '0;
        v_d    = '0;
        slc    = '0;
        for (int k = 0; k < STAGES; k++) begin
            slc = {1'b0, a_in[k][k*SW +: SW]}
                + {1'b0, b_in[k][k*SW +: SW]}
                + {{SW{1'b0}}, c_in[k]};
            a_d[k] = a_in[k];
            b_d[k] = b_in[k];
            s_d[k] = s_in[k];
            s_d[k][k*SW +: SW] = slc[SW-1:0];
            c_d[k] = slc[SW];
            v_d[k] = v_in[k];
        end
        // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out here.
        cm     = s_d[L][WIDTH-1] ^ a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1];
        ovf_d  = cm ^ c_d[L];
        zero_d = (s_d[L] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_d[k];
                    c_q[k] <= c_d[k];
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                end
            end
            if (rdy[L]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_q[L];
    assign bus.sum       = s_q[L];
    assign bus.cout      = c_q[L];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks for pipelined_adder plus a width/stage sweep.
// Results are compared as {zero, ovf, cout, sum[63:0]}.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_if #(.WIDTH(32)) bus();

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [66:0] obs,
                         input logic [66:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [66:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic s, input logic ci);
        logic [63:0] m, am, bm, r;
        logic [64:0] t;
        logic        c, o;
        m  = wmask(w);
        am = a & m;
        bm = (s ? ~b : b) & m;
        t  = {1'b0, am} + {1'b0, bm} + {64'd0, s | ci};
        r  = t[63:0] & m;
        c  = t[w];
        o  = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
        return {r == 64'd0, o, c, r};
    endfunction

    function automatic logic [66:0] mk(input logic [31:0] s, input logic c,
                                       input logic o, input logic z);
        return {z, o, c, 32'd0, s};
    endfunction

    function automatic logic [63:0] opnd(input logic [1:0] k, input int w,
                                         input logic [63:0] raw);
        case (k)
            2'd0:    return 64'd0;
            2'd1:    return wmask(w);
            2'd2:    return 64'd1 << (w - 1);
            default: return raw & wmask(w);
        endcase
    endfunction

    // Main-DUT scoreboard
    logic [66:0] cur_exp = '0;
    logic [66:0] mq[$];
    int          mcq[$];
    int          acc_cnt = 0;
    int          out_cnt = 0;
    logic        chk_lat = 1'b1;

    initial begin
        logic [66:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.in_valid && bus.in_ready) begin
                    mq.push_back(cur_exp);
                    mcq.push_back(cyc);
                    acc_cnt++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    out_cnt++;
                    if (mq.size() == 0) begin
                        check("spurious_out", 67'(bus.out_valid), 67'd0);
                    end else begin
                        e = mq.pop_front();
                        c = mcq.pop_front();
                        check("res", {bus.zero, bus.ovf, bus.cout, 32'd0, bus.sum}, e);
                        if (chk_lat) check("latency", 67'(cyc - c), 67'd4);
                    end
                end
            end
        end
    end

    task automatic put(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ci, input logic [66:0] e);
        logic ok;
        int   n;
        bus.in_valid = 1'b1;
        bus.x = a;
        bus.y = b;
        bus.sub = s;
        bus.cin = ci;
        cur_exp = e;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) check("accept_timeout", 67'(ok), 67'd1);
    endtask

    task automatic put_rand();
        logic [31:0] a, b;
        logic        s, ci;
        a  = $urandom;
        b  = $urandom;
        s  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        put(a, b, s, ci, model(32, {32'd0, a}, {32'd0, b}, s, ci));
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (mq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 67'(mq.size()), 67'd0);
    endtask

    // Sweep DUTs share one stimulus; each scores against its own width.
    logic        sw_valid = 1'b0;
    logic [1:0]  sw_ka = '0, sw_kb = '0;
    logic [63:0] sw_ra = '0, sw_rb = '0;
    logic        sw_sub = 1'b0, sw_cin = 1'b0;
    int          sw_pend[4] = '{default: 0};

    for (genvar i = 0; i < 4; i++) begin : g_sw
        localparam int W = (i == 0) ? 8 : (i == 1) ? 16 : (i == 2) ? 32 : 64;
        localparam int S = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 4;
        logic [63:0] ax, bx;
        logic [66:0] q[$];
        int          cq[$];

        pipelined_adder_if #(.WIDTH(W)) sif();
        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif)
        );

        assign ax            = opnd(sw_ka, W, sw_ra);
        assign bx            = opnd(sw_kb, W, sw_rb);
        assign sif.in_valid  = sw_valid;
        assign sif.x         = ax[W-1:0];
        assign sif.y         = bx[W-1:0];
        assign sif.sub       = sw_sub;
        assign sif.cin       = sw_cin;
        assign sif.out_ready = 1'b1;

        initial begin
            logic [66:0] e;
            int          c;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (sif.in_valid && sif.in_ready) begin
                        q.push_back(model(W, ax, bx, sw_sub, sw_cin));
                        cq.push_back(cyc);
                        sw_pend[i]++;
                    end
                    if (sif.out_valid) begin
                        if (q.size() == 0) begin
                            check("sw_spurious", 67'(sif.out_valid), 67'd0);
                        end else begin
                            e = q.pop_front();
                            c = cq.pop_front();
                            sw_pend[i]--;
                            check($sformatf("sw%0d_res", W),
                                  {sif.zero, sif.ovf, sif.cout, 64'(sif.sum)}, e);
                            check($sformatf("sw%0d_lat", W), 67'(cyc - c), 67'(S));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        int   vi;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 67'(bus.out_valid), 67'd0);
        check("rst_sum", 67'(bus.sum), 67'd0);
        check("rst_cout", 67'(bus.cout), 67'd0);
        check("rst_ovf", 67'(bus.ovf), 67'd0);
        check("rst_zero", 67'(bus.zero), 67'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 67'(bus.in_ready), 67'd1);
        @(posedge clk);
        #1;

        // Single beat: latency from acceptance
        put(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
        drain();

        // Directed vectors back to back
        put(32'h80000000, 32'h00000001, 1'b1, 1'b0, mk(32'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
        put(32'h00000005, 32'h00000007, 1'b1, 1'b0, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
        put(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b1, mk(32'h01000001, 1'b0, 1'b0, 1'b0));
        put(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
        put(32'h00000000, 32'h00000000, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
        put(32'h12345678, 32'h11111111, 1'b0, 1'b1, mk(32'h2345678A, 1'b0, 1'b0, 1'b0));
        put(32'h80000000, 32'h80000000, 1'b1, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
        put(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
        drain();

        // 100 random beats streamed
        for (int i = 0; i < 100; i++) put_rand();
        drain();

        // Backpressure: fill with out_ready low
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        out_cnt = 0;
        chk_lat = 1'b0;
        vi = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.x = 32'h1000 * (vi + 1);
            bus.y = 32'hF0F0F0F0 + vi;
            bus.sub = vi[0];
            bus.cin = 1'b1;
            cur_exp = model(32, {32'd0, bus.x}, {32'd0, bus.y}, bus.sub, 1'b1);
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) vi++;
        end
        @(negedge clk);
        check("bp_accepted", 67'(acc_cnt), 67'd4);
        check("bp_in_ready", 67'(bus.in_ready), 67'd0);
        check("bp_out_valid", 67'(bus.out_valid), 67'd1);
        check("bp_hold", {bus.zero, bus.ovf, bus.cout, 32'd0, bus.sum}, mq[0]);
        @(posedge clk);
        #1;
        // Release while full with a new beat pending: must pass through
        bus.out_ready = 1'b1;
        #1;
        check("full_pass", 67'(bus.in_ready), 67'd1);
        @(posedge clk);
        #1;
        drain();
        check("bp_count", 67'(out_cnt), 67'd5);

        // Reset with three beats in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) put_rand();
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_valid", 67'(bus.out_valid), 67'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 67'(bus.out_valid), 67'd0);
        check("mid_rst_outs", {bus.zero, bus.ovf, bus.cout, 32'd0, bus.sum}, 67'd0);
        mq.delete();
        mcq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        out_cnt = 0;
        chk_lat = 1'b1;
        @(posedge clk);
        #1;
        put_rand();
        drain();
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_count", 67'(out_cnt), 67'd1);

        // Parameter sweep: edge operands then random
        sw_valid = 1'b1;
        for (int ka = 0; ka < 3; ka++) begin
            for (int kb = 0; kb < 3; kb++) begin
                for (int m = 0; m < 4; m++) begin
                    sw_ka  = 2'(ka);
                    sw_kb  = 2'(kb);
                    sw_sub = 1'(m >> 1);
                    sw_cin = 1'(m & 1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        sw_ka = 2'd3;
        sw_kb = 2'd3;
        for (int i = 0; i < 40; i++) begin
            sw_ra  = {$urandom, $urandom};
            sw_rb  = {$urandom, $urandom};
            sw_sub = 1'($urandom_range(0, 1));
            sw_cin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check("sw_drain", 67'(sw_pend[i]), 67'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
